// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide sequencer
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [4:0]      LAST_ITER = 5'(ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state;
    logic [2:0]      f3;
    logic [XLEN-1:0] a_org;
    logic [XLEN-1:0] b_org;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [4:0]      cnt;
    logic            neg_res;
    logic            neg_rem;
    logic            dz;
    logic            ovf;
    logic            fix_step;
    logic [XLEN-1:0] res;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0] sel_res;

    // MULH/DIV/REM treat both operands as signed; MULHSU only rs1.
    always_comb begin
        a_signed  = (f3 == 3'b001) || (f3 == 3'b010) || (f3[2] && !f3[0]);
        b_signed  = (f3 == 3'b001) || (f3[2] && !f3[0]);
        a_neg     = a_signed && a_org[XLEN-1];
        b_neg     = b_signed && b_org[XLEN-1];
        abs_a     = a_neg ? ({XLEN{1'b0}} - a_org) : a_org;
        abs_b     = b_neg ? ({XLEN{1'b0}} - b_org) : b_org;
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        rem_shift = {hi, lo[XLEN-1]};
        trial     = rem_shift - {1'b0, opb};
        prod_neg  = {(2*XLEN){1'b0}} - {hi, lo};
    end

    always_comb begin
        sel_res = lo;
        case (f3)
            3'b000:                 sel_res = lo;
            3'b001, 3'b010, 3'b011: sel_res = hi;
            3'b100, 3'b101:         sel_res = dz ? {XLEN{1'b1}} : (ovf ? INT_MIN : lo);
            default:                sel_res = dz ? a_org : (ovf ? {XLEN{1'b0}} : hi);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            f3       <= 3'b000;
            a_org    <= '0;
            b_org    <= '0;
            opb      <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= 5'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            fix_step <= 1'b0;
            res      <= '0;
        end else if (flush && (state != S_IDLE)) begin
            state    <= S_IDLE;
            fix_step <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        f3    <= funct3;
                        a_org <= A;
                        b_org <= B;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    dz      <= f3[2] && (b_org == '0);
                    ovf     <= f3[2] && !f3[0] && (a_org == INT_MIN) && (b_org == {XLEN{1'b1}});
                    opb     <= abs_b;
                    hi      <= '0;
                    lo      <= abs_a;
                    cnt     <= 5'd0;
                    state   <= S_CALC;
                end
                S_CALC: begin
                    if (!f3[2]) begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end else if (!trial[XLEN]) begin
                        hi <= trial[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= rem_shift[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state    <= S_FIX;
                        fix_step <= 1'b0;
                    end
                end
                S_FIX: begin
                    // Sign fix-up and result selection are registered separately
                    // so the 64-bit negate never feeds the result mux directly.
                    if (!fix_step) begin
                        if (!f3[2]) begin
                            if (neg_res) {hi, lo} <= prod_neg;
                        end else begin
                            if (neg_res) lo <= {XLEN{1'b0}} - lo;
                            if (neg_rem) hi <= {XLEN{1'b0}} - hi;
                        end
                        fix_step <= 1'b1;
                    end else begin
                        res      <= sel_res;
                        fix_step <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign start_ready  = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_DONE);
    assign result       = res;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .funct3       (funct3),
        .A            (A),
        .B            (B),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_result(output logic [31:0] r, output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        funct3      = f;
        A           = a;
        B           = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        funct3      = ~f;
        A           = 32'hDEADBEEF;
        B           = 32'h12345678;
        wait_result(r, lat);
    endtask

    task automatic take_result(input string name);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check({name, "_ready_after"}, {31'd0, start_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        int          lat;
        bit          seen;

        rst_n = 1'b0; start_valid = 1'b0; funct3 = 3'b000; A = '0; B = '0;
        flush = 1'b0; result_ready = 1'b0;

        vecs.push_back('{"mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB});
        vecs.push_back('{"mulh_min_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back('{"mulh_m1_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{"mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{"mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        vecs.push_back('{"div_20_m3",    3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA});
        vecs.push_back('{"rem_20_m3",    3'b110, 32'd20,       32'hFFFFFFFD, 32'd2});
        vecs.push_back('{"divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14});
        vecs.push_back('{"remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2});
        vecs.push_back('{"divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF});
        vecs.push_back('{"remu_by0",     3'b111, 32'd5,        32'd0,        32'd5});
        vecs.push_back('{"div_m5_by0",   3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF});
        vecs.push_back('{"rem_m5_by0",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB});
        vecs.push_back('{"div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{"rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0});

        #1;
        check("reset_start_ready",  {31'd0, start_ready},  32'd1);
        check("reset_busy",         {31'd0, busy},         32'd0);
        check("reset_result_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result",       result,                32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat);
            check({vecs[i].name, "_latency"}, lat, 32'd35);
            check(vecs[i].name, r, vecs[i].exp);
            take_result(vecs[i].name);
        end

        // Backpressure: result and start_ready must hold while the consumer stalls.
        run_op(3'b101, 32'd100, 32'd7, r, lat);
        check("bp_latency", lat, 32'd35);
        held = r;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_result_stable", result, held);
            check("bp_valid_held", {31'd0, result_valid}, 32'd1);
            check("bp_start_ready_low", {31'd0, start_ready}, 32'd0);
        end
        take_result("bp");
        check("bp_valid_dropped", {31'd0, result_valid}, 32'd0);

        // Flush during CALC iteration 10.
        @(negedge clk);
        funct3 = 3'b000; A = 32'd9; B = 32'd9; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_start_ready", {31'd0, start_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        check("flush_no_result", {31'd0, seen}, 32'd0);
        run_op(3'b000, 32'd3, 32'd4, r, lat);
        check("after_flush_latency", lat, 32'd35);
        check("after_flush_mul", r, 32'd12);
        take_result("after_flush");

        // Reset asserted mid-CALC.
        @(negedge clk);
        funct3 = 3'b100; A = 32'd1000; B = 32'd3; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_start_ready",  {31'd0, start_ready},  32'd1);
        check("rst_mid_busy",         {31'd0, busy},         32'd0);
        check("rst_mid_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_mid_result",       result,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd4, r, lat);
        check("after_rst_latency", lat, 32'd35);
        check("after_rst_mul", r, 32'd12);
        take_result("after_rst");

        // Flush coincident with an accept in IDLE is ignored.
        @(negedge clk);
        funct3 = 3'b111; A = 32'd100; B = 32'd7; start_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0; flush = 1'b0;
        check("idle_flush_accepted", {31'd0, busy}, 32'd1);
        wait_result(r, lat);
        check("idle_flush_latency", lat, 32'd35);
        check("idle_flush_remu", r, 32'd2);
        take_result("idle_flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
